// File: rtl/spike_fifo.sv
// Synchronous spike/event FIFO with registered read data, occupancy count,
// almost-full threshold and sticky overflow/underflow diagnostics.
module spike_fifo #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 4,
    parameter int ALMOST_FULL_THRESH = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wen,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_AF    = (ADDR_WIDTH+1)'(ALMOST_FULL_THRESH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  wr_ok;
    logic                  rd_ok;

    // Flags come from the registered count only, so no input reaches an output
    // combinationally and pointer wrap never matters for full/empty.
    assign full        = (count == CNT_DEPTH);
    assign empty       = (count == '0);
    assign almost_full = (count >= CNT_AF);

    assign wr_ok = wen & ~full;
    assign rd_ok = read_en & ~empty;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_next = count;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    // NOTE: storage has no reset; stale words are unreachable because count and
    // the pointers are reset, and leaving the array unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dout      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_next;
            overflow  <= overflow | (wen & full);
            underflow <= underflow | (read_en & empty);
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            // A simultaneous write never targets rd_ptr here: that would need
            // full, which already blocks the write.
            if (rd_ok) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule
